// File: rtl/reg_writeback_ctrl.sv
// In-order write-back queue feeding the register file write port, with RAW hazard detection.
// Define WB_FORWARD_EN to build the youngest-match forwarding mux on FWD1_DATA/FWD2_DATA.
module reg_writeback_ctrl #(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 3,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ALU_VALID,
   output logic              ALU_READY,
   input  logic [ADDR_W-1:0] ALU_ADDR,
   input  logic [DATA_W-1:0] ALU_DATA,
   input  logic              MEM_VALID,
   output logic              MEM_READY,
   input  logic [ADDR_W-1:0] MEM_ADDR,
   input  logic [DATA_W-1:0] MEM_DATA,
   output logic [DATA_W-1:0] WB_DATA,
   output logic [ADDR_W-1:0] WB_ADDR,
   output logic              WB_WE,
   input  logic [ADDR_W-1:0] RD1_ADDR,
   input  logic [ADDR_W-1:0] RD2_ADDR,
   output logic              HAZARD1,
   output logic              HAZARD2,
   output logic [DATA_W-1:0] FWD1_DATA,
   output logic [DATA_W-1:0] FWD2_DATA,
   output logic [CNT_W-1:0]  COUNT
);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wb_we_q;
   logic [ADDR_W-1:0] wb_addr_q;
   logic [DATA_W-1:0] wb_data_q;

   logic              push, pop;
   logic [ADDR_W-1:0] push_addr;
   logic [DATA_W-1:0] push_data;

   // Fullness looks only at the registered count, so a pop on the same edge never frees a slot early.
   assign MEM_READY = !RESET && (count_q != CNT_W'(DEPTH));
   assign ALU_READY = MEM_READY && !MEM_VALID;

   assign push      = MEM_READY && (MEM_VALID || ALU_VALID);
   assign pop       = (count_q != '0);
   assign push_addr = MEM_VALID ? MEM_ADDR : ALU_ADDR;
   assign push_data = MEM_VALID ? MEM_DATA : ALU_DATA;

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples pre-edge values, like real flops.
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            wb_we_q   <= 1'b1;
            wb_addr_q <= addr_q[rd_ptr_q];
            wb_data_q <= data_q[rd_ptr_q];
         end else begin
            wb_we_q   <= 1'b0;
         end
      end
   end

   // NOTE: storage is deliberately not reset; pointers and count alone decide which slots are live.
   always_ff @(posedge CLK) begin
      if (push) begin
         addr_q[wr_ptr_q] <= push_addr;
         data_q[wr_ptr_q] <= push_data;
      end
   end

   assign WB_WE   = wb_we_q;
   assign WB_ADDR = wb_addr_q;
   assign WB_DATA = wb_data_q;
   assign COUNT   = count_q;

   // Slots listed oldest (k=0) to youngest, with a live flag per age position.
   logic [PTR_W-1:0] age_idx   [DEPTH];
   logic             age_valid [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_age
      assign age_idx[k]   = rd_ptr_q + PTR_W'(k);
      assign age_valid[k] = (CNT_W'(k) < count_q);
   end

   always_comb begin
      // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
      HAZARD1 = wb_we_q && (wb_addr_q == RD1_ADDR);
      HAZARD2 = wb_we_q && (wb_addr_q == RD2_ADDR);
      for (int k = 0; k < DEPTH; k++) begin
         if (age_valid[k] && (addr_q[age_idx[k]] == RD1_ADDR)) HAZARD1 = 1'b1;
         if (age_valid[k] && (addr_q[age_idx[k]] == RD2_ADDR)) HAZARD2 = 1'b1;
      end
   end

`ifdef WB_FORWARD_EN
   // WB stage is the oldest candidate; scanning queue slots oldest-first lets the youngest match win.
   always_comb begin
      FWD1_DATA = '0;
      FWD2_DATA = '0;
      if (wb_we_q && (wb_addr_q == RD1_ADDR)) FWD1_DATA = wb_data_q;
      if (wb_we_q && (wb_addr_q == RD2_ADDR)) FWD2_DATA = wb_data_q;
      for (int k = 0; k < DEPTH; k++) begin
         if (age_valid[k] && (addr_q[age_idx[k]] == RD1_ADDR)) FWD1_DATA = data_q[age_idx[k]];
         if (age_valid[k] && (addr_q[age_idx[k]] == RD2_ADDR)) FWD2_DATA = data_q[age_idx[k]];
      end
   end
`else
   assign FWD1_DATA = '0;
   assign FWD2_DATA = '0;
`endif

endmodule
